// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: FSM state encoding and default bit period.
// Shared by uart_rx and the future uart_tx.
// Optional feature macro UART_RX_PARITY_EN is left undefined by default
// (8N1 framing); define it on the command line to enable even parity.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
package uart_pkg;

  // 10 MHz system clock / 115200 baud
  localparam int UART_DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_2ff
// One-bit two-flop synchroniser for asynchronous inputs (serial line,
// buttons, switches). RESET_VAL selects the value both flops reset to.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; the first may go metastable, the second settles it
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx
// Byte-oriented UART receiver, 8N1, LSB first. Emits a one-cycle o_valid per
// correctly framed byte and a one-cycle o_frame_err when the stop bit is low.
// A held-low line after a bad stop bit parks in BREAK until the line idles.
// Optional: define UART_RX_PARITY_EN for an even-parity bit and o_parity_err.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_frame_err
);

  // Start-bit centre offset and full bit period, in counter width
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  logic        rx_s;
  uart_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic        par_q, par_d;
  logic        perr_q, perr_d;
`endif

  // Line idles high, so the synchroniser resets to 1 to avoid a false start
  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  // State, counters, shift register and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic: bit timing, sampling and end-of-frame decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line already back high at mid-start is a glitch
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[bit_q] = rx_s;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_q, par_q}) begin
              perr_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              data_d  = shift_q;
            end
`else
            valid_d = 1'b1;
            data_d  = shift_q;
`endif
          end else begin
            // Framing is checked first; parity is not reported here
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_busy      = busy_q;
  assign o_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_q;
`endif

endmodule : uart_rx
`default_nettype wire
